spi_frame_rx: RTL
=================

# spi_frame_rx

Receiver stage that sits directly downstream of the byte-serial SPI transmitter. It decodes the three-phase-per-bit line code (marker 1, data bit, guard 0; eight bits per byte, LSB first) while the frame enable is held low. Decoded bytes go into a small first-word-fall-through FIFO with a valid/ready read port, and line-code violations are flagged. Transmitter and receiver share one clock, so no clock recovery is performed.

## Interface
- DEPTH, 4, FIFO depth in bytes; power of 2, minimum 2.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- sdi  input  1  serial data line from the transmitter's data output.
- en_in  input  1  frame enable from the transmitter's enable output; active-low, low = frame in progress.
- clr  input  1  synchronous clear of the sticky flags frame_err and ovf.
- ready  input  1  consumer accepts the head byte on this edge.
- data_out  output  8  FIFO head byte; defined only while valid=1.
- valid  output  1  FIFO not empty.
- count  output  log2(DEPTH)+1  FIFO occupancy.
- busy  output  1  byte decode in progress (state is DATA, GUARD or MARK).
- frame_err  output  1  sticky: a line-code violation was detected.
- ovf  output  1  sticky: a completed byte was dropped because the FIFO was full.

## Operation
- Reset (rst=0, any time): FSM goes to IDLE. Partial byte discarded, FIFO emptied. Outputs: data_out=0, valid=0, count=0, busy=0, frame_err=0, ovf=0.
- States: IDLE, HUNT, DATA, GUARD, MARK. A 3-bit bit index and an 8-bit shift register hold the byte.
- IDLE: if en_in=1, stay. If en_in=0, go to HUNT.
- In every state except IDLE, en_in=1 aborts: discard the partial byte, go to IDLE, no push, no error.
- HUNT: sdi=1 → DATA, with bit index=0. sdi=0 → stay. This absorbs the transmitter's single 0 gap cycle between bytes.
- DATA: shift register takes sdi at the current bit index (LSB first) → GUARD.
- GUARD:
  - sdi=1 → set frame_err, discard the byte, go to HUNT.
  - sdi=0 and bit index<7 → increment the index, go to MARK.
  - sdi=0 and bit index=7 → push the byte, go to HUNT.
- MARK: sdi=1 → DATA. sdi=0 → set frame_err, discard the byte, go to HUNT.
- Push when count=DEPTH and no pop on the same edge: byte dropped, ovf set, FIFO unchanged.
- FIFO behaviour:
  - Pop occurs on an edge with valid=1 and ready=1; ready while empty is ignored.
  - Push and pop on the same edge: both happen and count is unchanged. This also applies when full (no ovf).
  - Pointers wrap modulo DEPTH.
- clr=1: clears frame_err and ovf. A new event on the same edge wins, so the flag ends up set.
- If the byte is pushed and en_in rises in the cycle after the final guard, the byte is still kept.

## Timing
- Notation: edge k0 is the posedge at which HUNT samples sdi=1.
- Sampling: bit i data at k0+3i+1; guard at k0+3i+2; marker for bit i+1 at k0+3i+3.
- The byte is written at edge k0+23. After that edge: valid=1, data_out=byte, count incremented.
- Latency: 1 cycle from the last guard sample to valid; 23 cycles from the marker sample.
- With the transmitter's 1-cycle gap, the next marker is sampled at k0+25. Sustained rate is 1 byte per 25 cycles.
- No bypass: a push into an empty FIFO is visible next cycle; data_out holds the head until the pop edge.
- busy=1 from the cycle after the k0 edge through the cycle before the edge that leaves GUARD for HUNT.
- frame_err and ovf are registered: high the cycle after the detecting edge.

## Test plan
- Send 0xA5 after en_in falls → valid rises after edge k0+23, data_out=0xA5, count=1. With ready=1 for one edge: valid=0, count=0.
- Send 0x3C then 0xC3 with the standard 1-cycle gap, ready=0 → count=2. Pops return 0x3C, then 0xC3. frame_err=0.
- Force sdi=1 in the guard phase of bit 3 of 0x0F → frame_err=1, count unchanged. A following 0x5A is received correctly. clr=1 → frame_err=0.
- Raise en_in after bit 4 of 0xFF → no push, busy=0, FSM in IDLE. The next frame 0x81 decodes as 0x81.
- DEPTH=4, send 5 bytes 0x01..0x05 with ready=0 → count=4, ovf=1, pops give 0x01..0x04. Repeat with ready=1 on the 5th byte's push edge → ovf stays 0 and 0x05 is retained.
- Assert rst=0 mid-byte (bit 2) with 2 bytes queued → immediately valid=0, count=0, busy=0, flags 0. After release, 0x7E decodes correctly.

Source files
------------

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: decodes marker/data/guard line-coded bytes into a first-word-fall-through FIFO
module spi_frame_rx #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sdi,
  input  logic                     en_in,
  input  logic                     clr,
  input  logic                     ready,
  output logic [7:0]               data_out,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, HUNT, DATA, GUARD, MARK} state_t;
  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ferr_q, ferr_d, ovf_q, ovf_d;
  logic          push, err, pop, drop, wr;
  // line-code decoder: en_in high aborts any frame without pushing or flagging
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sh_d = sh_q;
    push = 1'b0;
    err = 1'b0;
    if (state_q != IDLE && en_in) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: state_d = en_in ? IDLE : HUNT;
        HUNT: begin
          state_d = sdi ? DATA : HUNT;
          idx_d = sdi ? 3'd0 : idx_q;
        end
        DATA: begin
          sh_d[idx_q] = sdi;
          state_d = GUARD;
        end
        GUARD: begin
          err = sdi;
          push = !sdi && idx_q == 3'd7;
          idx_d = (!sdi && idx_q != 3'd7) ? idx_q + 3'd1 : idx_q;
          state_d = (!sdi && idx_q != 3'd7) ? MARK : HUNT;
        end
        MARK: begin
          err = !sdi;
          state_d = sdi ? DATA : HUNT;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // FIFO bookkeeping: a full FIFO still accepts a push when the head pops on the same edge
  always_comb begin
    pop = cnt_q != '0 && ready;
    drop = push && cnt_q == FULL && !pop;
    wr = push && !drop;
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = sh_q;
    wp_d = wr ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    ferr_d = err | (ferr_q & ~clr);
    ovf_d = drop | (ovf_q & ~clr);
  end
  // state, shift register, FIFO storage and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      sh_q <= '0;
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ferr_q <= ferr_d;
      ovf_q <= ovf_d;
    end
  end
  assign valid = cnt_q != '0;
  assign data_out = valid ? mem_q[rp_q] : 8'h00;
  assign count = cnt_q;
  assign busy = state_q == DATA || state_q == GUARD || state_q == MARK;
  assign frame_err = ferr_q;
  assign ovf = ovf_q;
endmodule
